register_delay_bank: RTL and testbench

REGISTER_DELAY_BANK -- requirements
Module: register_delay_bank

---
 rtl/register_delay_bank.sv | 183 ++++++++++++++++++
 tb/tb_register_delay_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_delay_bank.sv
// -----------------------------------------------------------------------------
// register_delay_bank
//
// Purpose:
//   A small bank of addressable data entries, each with an "occupied" flag.
//   A write deposits data into an entry and marks it occupied. A read returns
//   the entry's data one cycle later and consumes the entry, clearing its flag.
//   Entry 0 is a permanent null slot: it reads as zero and is never occupied.
//   Two sticky error flags record writes onto unconsumed entries and reads of
//   empty entries.
//
// Parameters:
//   D  data width in bits (>= 1)
//   A  address width in bits (>= 1); the bank holds R = 2**A entries
//
// Ports:
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous active-high reset
//   wr_en          in   1     write request
//   wr_addr        in   A     write entry index
//   wr_data        in   D     write data
//   rd_en          in   1     read-and-consume request
//   rd_addr        in   A     read entry index
//   clr_err        in   1     synchronous clear of the sticky error flags
//   rd_data        out  D     registered read data (held when no read)
//   rd_valid       out  1     registered; high for one cycle after a read of
//                             an occupied entry
//   entry_valid    out  R     per-entry occupied flags, bit 0 always 0
//   occupancy      out  A+1   number of occupied entries
//   full           out  1     all entries 1..R-1 occupied
//   empty          out  1     no entry occupied
//   overwrite_err  out  1     sticky: a write hit an occupied, unconsumed entry
//   underflow_err  out  1     sticky: a read hit an unoccupied entry 1..R-1
// -----------------------------------------------------------------------------
module register_delay_bank #(
  parameter int D = 7,
  parameter int A = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [D-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [A-1:0]      rd_addr,
  input  logic              clr_err,
  output logic [D-1:0]      rd_data,
  output logic              rd_valid,
  output logic [(2**A)-1:0] entry_valid,
  output logic [A:0]        occupancy,
  output logic              full,
  output logic              empty,
  output logic              overwrite_err,
  output logic              underflow_err
);

  localparam int        R          = 2**A;
  localparam logic [A:0] FULL_COUNT = (A+1)'(R - 1);

  // Flattened view of every entry; element/bit 0 is the null slot.
  logic [D-1:0] w_data [R];
  logic [R-1:0] w_valid;

  logic         w_rd_nonzero;
  logic         w_wr_nonzero;
  logic         w_rd_live;
  logic         w_underflow_set;
  logic         w_overwrite_set;
  logic [A:0]   w_occupancy;

  logic [D-1:0] r_rd_data;
  logic         r_rd_valid;
  logic         r_overwrite_err;
  logic         r_underflow_err;

  // ---------------------------------------------------------------------------
  // Entry 0: constant null slot, no storage behind it.
  // ---------------------------------------------------------------------------
  assign w_data[0]  = '0;
  assign w_valid[0] = 1'b0;

  // ---------------------------------------------------------------------------
  // Entries 1..R-1: one data word and one occupied flag each.
  // A write wins over a same-cycle read of the same entry, so the entry ends
  // occupied with the new data while the read still returns the old word
  // (the read mux below samples the pre-edge contents).
  // ---------------------------------------------------------------------------
  for (genvar gi = 1; gi < R; gi++) begin : g_entry
    logic         w_wr_hit;
    logic         w_rd_hit;
    logic [D-1:0] r_word;
    logic         r_valid;

    assign w_wr_hit = wr_en && (wr_addr == A'(gi));
    assign w_rd_hit = rd_en && (rd_addr == A'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_word  <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_wr_hit) begin
          r_word  <= wr_data;
          r_valid <= 1'b1;
        end else if (w_rd_hit) begin
          r_valid <= 1'b0;
        end
      end
    end

    assign w_data[gi]  = r_word;
    assign w_valid[gi] = r_valid;
  end

  // ---------------------------------------------------------------------------
  // Request classification, all against pre-edge state.
  // ---------------------------------------------------------------------------
  assign w_rd_nonzero = (rd_addr != '0);
  assign w_wr_nonzero = (wr_addr != '0);

  // A read only produces data when it targets an occupied real entry.
  assign w_rd_live = rd_en && w_rd_nonzero && w_valid[rd_addr];

  assign w_underflow_set = rd_en && w_rd_nonzero && !w_valid[rd_addr];

  // A same-cycle read of the written entry consumes the old value first, so
  // that write does not count as clobbering unconsumed data.
  assign w_overwrite_set = wr_en && w_wr_nonzero && w_valid[wr_addr] &&
                           !(rd_en && (rd_addr == wr_addr));

  // ---------------------------------------------------------------------------
  // Registered read port. rd_data holds its value on idle cycles; a read that
  // misses drives zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd_en) begin
      r_rd_valid <= w_rd_live;
      r_rd_data  <= w_rd_live ? w_data[rd_addr] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set event in the clearing cycle keeps the flag high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overwrite_err <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_overwrite_err <= w_overwrite_set || (r_overwrite_err && !clr_err);
      r_underflow_err <= w_underflow_set || (r_underflow_err && !clr_err);
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy is a population count of the registered flags, so it tracks
  // them with no extra latency and can never drift out of range.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_occupancy = '0;
    for (int i = 1; i < R; i++) begin
      w_occupancy = w_occupancy + (A+1)'(w_valid[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign entry_valid   = w_valid;
  assign occupancy     = w_occupancy;
  assign full          = (w_occupancy == FULL_COUNT);
  assign empty         = (w_occupancy == '0);
  assign overwrite_err = r_overwrite_err;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_register_delay_bank.sv
// -----------------------------------------------------------------------------
// tb_register_delay_bank
//
// Directed testbench for register_delay_bank with D=7, A=3. A linear sequence
// of steps drives the bank and checks outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_register_delay_bank;

  localparam int D = 7;
  localparam int A = 3;
  localparam int R = 2**A;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic         clr_err;
  logic [D-1:0] rd_data;
  logic         rd_valid;
  logic [R-1:0] entry_valid;
  logic [A:0]   occupancy;
  logic         full;
  logic         empty;
  logic         overwrite_err;
  logic         underflow_err;

  int total = 0;
  int bad   = 0;

  register_delay_bank #(.D(D), .A(A)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .clr_err      (clr_err),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .entry_valid  (entry_valid),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .overwrite_err(overwrite_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic drive_wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = A'(addr);
    wr_data = D'(data);
  endtask

  task automatic drive_rd(input int addr);
    rd_en   = 1'b1;
    rd_addr = A'(addr);
  endtask

  initial begin
    rst     = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle();

    // Reset state, observed before any clock edge.
    #2;
    check("rst_rd_data",     32'(rd_data),     32'h0);
    check("rst_rd_valid",    32'(rd_valid),    32'h0);
    check("rst_entry_valid", 32'(entry_valid), 32'h0);
    check("rst_occupancy",   32'(occupancy),   32'h0);
    check("rst_empty",       32'(empty),       32'h1);
    check("rst_full",        32'(full),        32'h0);
    check("rst_ovf_err",     32'(overwrite_err), 32'h0);
    check("rst_unf_err",     32'(underflow_err), 32'h0);
    step();
    rst = 1'b0;

    // Write 0x55 to entry 3, then read it back with one-cycle latency.
    drive_wr(3, 'h55);
    step();
    idle();
    check("w3_entry_valid", 32'(entry_valid), 32'h08);
    check("w3_occupancy",   32'(occupancy),   32'h1);
    check("w3_empty",       32'(empty),       32'h0);
    drive_rd(3);
    step();
    idle();
    check("r3_rd_data",     32'(rd_data),     32'h55);
    check("r3_rd_valid",    32'(rd_valid),    32'h1);
    check("r3_entry_valid", 32'(entry_valid), 32'h00);
    check("r3_occupancy",   32'(occupancy),   32'h0);
    check("r3_empty",       32'(empty),       32'h1);
    step();
    check("idle_rd_valid",  32'(rd_valid),    32'h0);
    check("idle_rd_hold",   32'(rd_data),     32'h55);

    // Fill entries 1..7 with their own index.
    for (int i = 1; i < R; i++) begin
      drive_wr(i, i);
      step();
    end
    idle();
    check("fill_full",        32'(full),          32'h1);
    check("fill_occupancy",   32'(occupancy),     32'h7);
    check("fill_entry_valid", 32'(entry_valid),   32'hFE);
    check("fill_ovf_err",     32'(overwrite_err), 32'h0);

    // Write while full lands on an occupied entry: overwrite, never dropped.
    drive_wr(7, 'h7F);
    step();
    idle();
    check("wfull_ovf_err",   32'(overwrite_err), 32'h1);
    check("wfull_occupancy", 32'(occupancy),     32'h7);
    check("wfull_full",      32'(full),          32'h1);

    drive_rd(5);
    step();
    idle();
    check("r5_rd_data",     32'(rd_data),     32'h05);
    check("r5_rd_valid",    32'(rd_valid),    32'h1);
    check("r5_full",        32'(full),        32'h0);
    check("r5_occupancy",   32'(occupancy),   32'h6);
    check("r5_entry_valid", 32'(entry_valid), 32'hDE);
    drive_rd(7);
    step();
    idle();
    check("r7_rd_data",     32'(rd_data),     32'h7F);

    // Reset pulse between edges to start from a clean bank.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst2_occupancy", 32'(occupancy),     32'h0);
    check("rst2_ovf_err",   32'(overwrite_err), 32'h0);
    rst = 1'b0;

    // Same-address write and read: read sees the old word, entry keeps new.
    drive_wr(2, 'h11);
    step();
    drive_wr(2, 'h22);
    drive_rd(2);
    step();
    idle();
    check("rw2_rd_data",     32'(rd_data),       32'h11);
    check("rw2_rd_valid",    32'(rd_valid),      32'h1);
    check("rw2_entry_valid", 32'(entry_valid),   32'h04);
    check("rw2_ovf_err",     32'(overwrite_err), 32'h0);
    check("rw2_unf_err",     32'(underflow_err), 32'h0);

    // Different-address write and read in the same cycle.
    drive_wr(4, 'h33);
    drive_rd(2);
    step();
    idle();
    check("w4r2_rd_data",     32'(rd_data),     32'h22);
    check("w4r2_rd_valid",    32'(rd_valid),    32'h1);
    check("w4r2_entry_valid", 32'(entry_valid), 32'h10);
    check("w4r2_occupancy",   32'(occupancy),   32'h1);

    // Double write with no read, then read of an empty entry.
    drive_wr(3, 'h01);
    step();
    drive_wr(3, 'h02);
    step();
    idle();
    check("ww3_ovf_err", 32'(overwrite_err), 32'h1);
    check("ww3_unf_err", 32'(underflow_err), 32'h0);
    drive_rd(6);
    step();
    idle();
    check("r6_rd_valid", 32'(rd_valid),      32'h0);
    check("r6_rd_data",  32'(rd_data),       32'h0);
    check("r6_unf_err",  32'(underflow_err), 32'h1);

    // Clear coinciding with a fresh underflow keeps underflow set.
    drive_rd(6);
    clr_err = 1'b1;
    step();
    idle();
    check("clr_set_unf_err", 32'(underflow_err), 32'h1);
    check("clr_set_ovf_err", 32'(overwrite_err), 32'h0);
    clr_err = 1'b1;
    step();
    idle();
    check("clr_unf_err", 32'(underflow_err), 32'h0);
    check("clr_ovf_err", 32'(overwrite_err), 32'h0);
    drive_rd(3);
    step();
    idle();
    check("r3b_rd_data",  32'(rd_data),  32'h02);
    check("r3b_rd_valid", 32'(rd_valid), 32'h1);

    // Entry 0: write ignored, read returns zero, no errors.
    drive_wr(0, 'h7F);
    drive_rd(0);
    step();
    idle();
    check("a0_rd_data",     32'(rd_data),       32'h0);
    check("a0_rd_valid",    32'(rd_valid),      32'h0);
    check("a0_occupancy",   32'(occupancy),     32'h1);
    check("a0_entry_valid", 32'(entry_valid),   32'h10);
    check("a0_ovf_err",     32'(overwrite_err), 32'h0);
    check("a0_unf_err",     32'(underflow_err), 32'h0);

    // Entries 1 and 4 occupied with a pending read output, then mid-cycle reset.
    drive_wr(1, 'h0A);
    step();
    drive_wr(4, 'h44);
    drive_rd(4);
    step();
    idle();
    check("pre_rst_rd_data",     32'(rd_data),     32'h33);
    check("pre_rst_rd_valid",    32'(rd_valid),    32'h1);
    check("pre_rst_entry_valid", 32'(entry_valid), 32'h12);
    check("pre_rst_occupancy",   32'(occupancy),   32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_entry_valid", 32'(entry_valid), 32'h00);
    check("mid_rst_occupancy",   32'(occupancy),   32'h0);
    check("mid_rst_empty",       32'(empty),       32'h1);
    check("mid_rst_full",        32'(full),        32'h0);
    check("mid_rst_rd_data",     32'(rd_data),     32'h0);
    check("mid_rst_rd_valid",    32'(rd_valid),    32'h0);
    rst = 1'b0;
    drive_rd(1);
    step();
    idle();
    check("post_rst_rd_valid", 32'(rd_valid),      32'h0);
    check("post_rst_rd_data",  32'(rd_data),       32'h0);
    check("post_rst_unf_err",  32'(underflow_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
